// File: rtl/opfetch.sv
// opfetch: operand-fetch stage of the rv6 hart pipeline, sitting between
// decode and execute.
//
// Purpose:
//   - Drives the register-file read indices straight from decode.
//   - Resolves each source operand from x0, the bypass network or the
//     register-file read data.
//   - Stalls decode on hazards.
//   - Registers the resolved operands into a valid/ready pipeline register
//     that execute consumes.
//
// Build option:
//   RV6_OPFETCH_FWD_EN
//     defined   : EX > MEM > WB > register-file bypass. Only a load still
//                 in EX stalls.
//     undefined : only the WB bypass is kept. Any used source that matches
//                 a valid EX or MEM destination stalls, so a dependent
//                 instruction waits up to 2 cycles.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   flush               kill the held operand and the incoming decode slot
//   id_valid/id_ready   decode handshake
//   id_rs1/rs2/rd       register indices
//   id_use_rs1/rs2      instruction reads rs1/rs2
//   id_imm, id_pc       immediate and PC
//   id_ctrl             opaque decoded control, CTRL_W bits
//   rs1, rs2 / r1, r2   register-file read index / read data
//   ex_*, mem_*, wb_*   producer results for the bypass network
//   op_valid/op_ready   execute handshake
//   op_a, op_b          resolved operands
//   op_imm, op_pc       immediate and PC
//   op_rd, op_ctrl      destination register and decoded control
module opfetch #(
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [63:0]       id_imm,
    input  logic [63:0]       id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    input  logic [63:0]       r1,
    input  logic [63:0]       r2,
    input  logic              ex_vld,
    input  logic [4:0]        ex_rd,
    input  logic [63:0]       ex_d,
    input  logic              ex_load,
    input  logic              mem_vld,
    input  logic [4:0]        mem_rd,
    input  logic [63:0]       mem_d,
    input  logic              wb_wr,
    input  logic [4:0]        wb_rd,
    input  logic [63:0]       wb_d,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [63:0]       op_a,
    output logic [63:0]       op_b,
    output logic [63:0]       op_imm,
    output logic [63:0]       op_pc,
    output logic [4:0]        op_rd,
    output logic [CTRL_W-1:0] op_ctrl
);

    logic              op_valid_q, op_valid_d;
    logic [63:0]       op_a_q, op_a_d;
    logic [63:0]       op_b_q, op_b_d;
    logic [63:0]       op_imm_q, op_imm_d;
    logic [63:0]       op_pc_q, op_pc_d;
    logic [4:0]        op_rd_q, op_rd_d;
    logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;

    logic        hazard_rs1, hazard_rs2, hazard;
    logic        adv;
    logic [63:0] opnd_a, opnd_b;

    assign rs1 = id_rs1;
    assign rs2 = id_rs2;

`ifdef RV6_OPFETCH_FWD_EN
    // Only a load still in EX has no data to forward yet.
    assign hazard_rs1 = id_use_rs1 && (id_rs1 != 5'd0) &&
                        ex_vld && (ex_rd == id_rs1) && ex_load;
    assign hazard_rs2 = id_use_rs2 && (id_rs2 != 5'd0) &&
                        ex_vld && (ex_rd == id_rs2) && ex_load;
`else
    // No EX/MEM bypass: wait until the producer reaches WB.
    assign hazard_rs1 = id_use_rs1 && (id_rs1 != 5'd0) &&
                        ((ex_vld && (ex_rd == id_rs1)) ||
                         (mem_vld && (mem_rd == id_rs1)));
    assign hazard_rs2 = id_use_rs2 && (id_rs2 != 5'd0) &&
                        ((ex_vld && (ex_rd == id_rs2)) ||
                         (mem_vld && (mem_rd == id_rs2)));

    // These inputs only feed the bypass network, which is absent here.
    logic unused_fwd;
    assign unused_fwd = ^{ex_d, ex_load, mem_d};
`endif

    assign hazard   = hazard_rs1 || hazard_rs2;
    assign adv      = !op_valid_q || op_ready;
    assign id_ready = adv && !hazard && !flush;

    // The WB bypass covers a register-file write and read in the same cycle.
    always_comb begin
        opnd_a = r1;
        if (id_rs1 == 5'd0)
            opnd_a = '0;
`ifdef RV6_OPFETCH_FWD_EN
        else if (ex_vld && (ex_rd == id_rs1) && !ex_load)
            opnd_a = ex_d;
        else if (mem_vld && (mem_rd == id_rs1))
            opnd_a = mem_d;
`endif
        else if (wb_wr && (wb_rd == id_rs1))
            opnd_a = wb_d;
    end

    always_comb begin
        opnd_b = r2;
        if (id_rs2 == 5'd0)
            opnd_b = '0;
`ifdef RV6_OPFETCH_FWD_EN
        else if (ex_vld && (ex_rd == id_rs2) && !ex_load)
            opnd_b = ex_d;
        else if (mem_vld && (mem_rd == id_rs2))
            opnd_b = mem_d;
`endif
        else if (wb_wr && (wb_rd == id_rs2))
            opnd_b = wb_d;
    end

    // Data fields change only on a load. A bubble or a flush clears the
    // valid bit and leaves stale data behind.
    always_comb begin
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_imm_d   = op_imm_q;
        op_pc_d    = op_pc_q;
        op_rd_d    = op_rd_q;
        op_ctrl_d  = op_ctrl_q;
        if (flush) begin
            op_valid_d = 1'b0;
        end else if (adv && id_valid && !hazard) begin
            op_valid_d = 1'b1;
            op_a_d     = opnd_a;
            op_b_d     = opnd_b;
            op_imm_d   = id_imm;
            op_pc_d    = id_pc;
            op_rd_d    = id_rd;
            op_ctrl_d  = id_ctrl;
        end else if (adv) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_imm_q   <= '0;
            op_pc_q    <= '0;
            op_rd_q    <= '0;
            op_ctrl_q  <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_imm_q   <= op_imm_d;
            op_pc_q    <= op_pc_d;
            op_rd_q    <= op_rd_d;
            op_ctrl_q  <= op_ctrl_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_imm   = op_imm_q;
    assign op_pc    = op_pc_q;
    assign op_rd    = op_rd_q;
    assign op_ctrl  = op_ctrl_q;

endmodule
